// File: rtl/ex_cpuid_probe_pkg.sv
// rtl/ex_cpuid_probe_pkg.sv - shared state encoding and constants for the CPUID probe
package ex_cpuid_probe_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WSET  = 3'd1,
        WCAP  = 3'd2,
        RWAIT = 3'd3,
        RCAP  = 3'd4
    } state_e;

    localparam logic [4:0] CPUID_IDX_RNG = 5'h1F;
    localparam int         SNAP_DEPTH    = 8;

endpackage

// File: rtl/ex_cpuid_probe_if.sv
// rtl/ex_cpuid_probe_if.sv - responder, snapshot read and entropy signals of the CPUID probe
interface ex_cpuid_probe_if;
    logic        start;
    logic [4:0]  cpuIndex;
    logic [63:0] cpuResLo;
    logic [63:0] cpuResHi;
    logic        busy;
    logic        done;
    logic [2:0]  rdAddr;
    logic [63:0] rdData;
    logic [63:0] rdDataHi;
    logic        rngReq;
    logic        rngAck;
    logic [63:0] rngData;

    modport master (
        output start, cpuResLo, cpuResHi, rdAddr, rngReq,
        input  cpuIndex, busy, done, rdData, rdDataHi, rngAck, rngData
    );

    modport slave (
        input  start, cpuResLo, cpuResHi, rdAddr, rngReq,
        output cpuIndex, busy, done, rdData, rdDataHi, rngAck, rngData
    );
endinterface

// File: rtl/ex_cpuid_probe_gap.sv
// rtl/ex_cpuid_probe_gap.sv - saturating down-counter spacing entropy samples
module ex_cpuid_probe_gap #(
    parameter int GAP = 32
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    output logic zero
);

    logic [7:0] cnt_q, cnt_d;

    // reload wins over the free-running decrement, which stops at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = 8'(GAP);
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    // counter register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == 8'd0);

endmodule

// File: rtl/ex_cpuid_probe.sv
// rtl/ex_cpuid_probe.sv - CPUID walk snapshot and optional entropy sampler (JX2_CPUID_PROBE_RNG_EN)
module ex_cpuid_probe
    import ex_cpuid_probe_pkg::*;
#(
    parameter int WALK_LAST  = 3,
    parameter int SETTLE_CYC = 1,
    parameter int RNG_GAP    = 32
) (
    input logic              clock,
    input logic              reset,
    ex_cpuid_probe_if.slave  bus
);

    localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYC - 1);
    localparam logic [4:0] IDX_LAST    = 5'(WALK_LAST);

    state_e      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [2:0]  settle_q, settle_d;
    logic        done_q, done_d;
    logic [63:0] snap_lo_q [SNAP_DEPTH];
    logic [63:0] snap_lo_d [SNAP_DEPTH];
    logic [63:0] snap_hi_q [SNAP_DEPTH];
    logic [63:0] snap_hi_d [SNAP_DEPTH];

`ifdef JX2_CPUID_PROBE_RNG_EN
    logic [63:0] rng_data_q, rng_data_d;
    logic        gap_load;
    logic        gap_zero;

    ex_cpuid_probe_gap #(.GAP(RNG_GAP)) u_gap (
        .clock (clock),
        .reset (reset),
        .load  (gap_load),
        .zero  (gap_zero)
    );
`else
    logic unused_rng_req;
    assign unused_rng_req = bus.rngReq;
`endif

    // walk / entropy sequencing; only IDLE accepts new work, so start while busy is dropped
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        settle_d  = settle_q;
        done_d    = done_q;
        snap_lo_d = snap_lo_q;
        snap_hi_d = snap_hi_q;
`ifdef JX2_CPUID_PROBE_RNG_EN
        rng_data_d = rng_data_q;
        gap_load   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                idx_d = 5'd0;
                if (bus.start) begin
                    state_d  = WSET;
                    done_d   = 1'b0;
                    settle_d = 3'd0;
`ifdef JX2_CPUID_PROBE_RNG_EN
                end else if (bus.rngReq && gap_zero) begin
                    state_d  = RWAIT;
                    idx_d    = CPUID_IDX_RNG;
                    settle_d = 3'd0;
`endif
                end
            end
            WSET: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = WCAP;
                end else begin
                    settle_d = settle_q + 3'd1;
                end
            end
            WCAP: begin
                snap_lo_d[idx_q[2:0]] = bus.cpuResLo;
                snap_hi_d[idx_q[2:0]] = bus.cpuResHi;
                if (idx_q == IDX_LAST) begin
                    done_d  = 1'b1;
                    idx_d   = 5'd0;
                    state_d = IDLE;
                end else begin
                    idx_d    = idx_q + 5'd1;
                    settle_d = 3'd0;
                    state_d  = WSET;
                end
            end
`ifdef JX2_CPUID_PROBE_RNG_EN
            RWAIT: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = RCAP;
                end else begin
                    settle_d = settle_q + 3'd1;
                end
            end
            RCAP: begin
                rng_data_d = bus.cpuResLo;
                gap_load   = 1'b1;
                idx_d      = 5'd0;
                state_d    = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
                idx_d   = 5'd0;
            end
        endcase
    end

    // state, index and snapshot registers; reset wipes any partial walk
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            idx_q     <= 5'd0;
            settle_q  <= 3'd0;
            done_q    <= 1'b0;
            snap_lo_q <= '{default: '0};
            snap_hi_q <= '{default: '0};
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            settle_q  <= settle_d;
            done_q    <= done_d;
            snap_lo_q <= snap_lo_d;
            snap_hi_q <= snap_hi_d;
        end
    end

`ifdef JX2_CPUID_PROBE_RNG_EN
    // entropy word holding register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rng_data_q <= 64'd0;
        end else begin
            rng_data_q <= rng_data_d;
        end
    end

    // ack is the RCAP cycle itself; the word is forwarded then and held afterwards
    assign bus.rngAck  = (state_q == RCAP);
    assign bus.rngData = (state_q == RCAP) ? bus.cpuResLo : rng_data_q;
`else
    assign bus.rngAck  = 1'b0;
    assign bus.rngData = 64'd0;
`endif

    assign bus.cpuIndex = idx_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.rdData   = (32'(bus.rdAddr) <= WALK_LAST) ? snap_lo_q[bus.rdAddr] : 64'd0;
    assign bus.rdDataHi = (32'(bus.rdAddr) <= WALK_LAST) ? snap_hi_q[bus.rdAddr] : 64'd0;

endmodule

// File: tb/tb_ex_cpuid_probe.sv
// tb/tb_ex_cpuid_probe.sv - self-checking bench for ex_cpuid_probe
module tb_ex_cpuid_probe;

    localparam int WL       = 3;
    localparam int SC       = 1;
    localparam int GAP      = 32;
    localparam int WALK_LAT = (WL + 1) * (SC + 1) + 1;

    typedef struct {
        logic [2:0]  addr;
        logic [63:0] exp_lo;
        logic [63:0] exp_hi;
    } rd_vec_t;

    logic clock;
    logic reset;
    int   n_vec;
    int   n_bad;

    rd_vec_t     vecs [8];
    logic [63:0] sb_q [$];

    ex_cpuid_probe_if bus ();

    ex_cpuid_probe #(.WALK_LAST(WL), .SETTLE_CYC(SC), .RNG_GAP(GAP)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    function automatic logic [63:0] resp_lo(input logic [4:0] idx);
        return 64'h2020324632584A42 ^ ({59'd0, idx} * 64'h0101010101010101);
    endfunction

    function automatic logic [63:0] resp_hi(input logic [4:0] idx);
        return {32'hC0DE0000 | {27'd0, idx}, 32'h600DF00D};
    endfunction

    assign bus.cpuResLo = resp_lo(bus.cpuIndex);
    assign bus.cpuResHi = resp_hi(bus.cpuIndex);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_table(input string tag, input bit expect_zero);
        for (int i = 0; i < 8; i++) begin
            bus.rdAddr = vecs[i].addr;
            sb_q.push_back(expect_zero ? 64'd0 : vecs[i].exp_lo);
            sb_q.push_back(expect_zero ? 64'd0 : vecs[i].exp_hi);
            #1;
            check($sformatf("%s_lo[%0d]", tag, i), bus.rdData, sb_q.pop_front());
            check($sformatf("%s_hi[%0d]", tag, i), bus.rdDataHi, sb_q.pop_front());
        end
        bus.rdAddr = 3'd0;
    endtask

    task automatic run_walk(input string tag, input int restart_at);
        int done_k;
        sb_q.push_back(64'(WALK_LAT));
        bus.start = 1'b1;
        done_k = -1;
        for (int k = 1; k <= 20 && done_k < 0; k++) begin
            tick();
            bus.start = (k == restart_at - 1);
            if (bus.done) done_k = k;
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, 64'(done_k), sb_q.pop_front());
    endtask

    initial begin
        int ack_k;
        int done_k;
        int cnt_ack;
        int cnt_idx;

        n_vec = 0;
        n_bad = 0;
        for (int i = 0; i < 8; i++) begin
            vecs[i].addr   = 3'(i);
            vecs[i].exp_lo = (i <= WL) ? resp_lo(5'(i)) : 64'd0;
            vecs[i].exp_hi = (i <= WL) ? resp_hi(5'(i)) : 64'd0;
        end

        bus.start  = 1'b0;
        bus.rdAddr = 3'd0;
        bus.rngReq = 1'b0;
        reset      = 1'b0;
        idle(3);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_index", 64'(bus.cpuIndex), 64'd0);
        check("rst_rng_ack", 64'(bus.rngAck), 64'd0);
        check("rst_rng_data", bus.rngData, 64'd0);
        check_table("rst", 1'b1);
        reset = 1'b1;
        idle(2);

        // basic walk
        run_walk("walk", 0);
        check("walk_busy_after", 64'(bus.busy), 64'd0);
        check("walk_index_after", 64'(bus.cpuIndex), 64'd0);
        bus.rdAddr = 3'd0;
        #1;
        check("walk_rd0_literal", bus.rdData, 64'h2020324632584A42);
        check_table("walk", 1'b0);
        idle(2);

        // second start while busy is ignored
        run_walk("restart", 3);
        idle(3);
        check("restart_busy_after", 64'(bus.busy), 64'd0);
        check_table("restart", 1'b0);

        // reset in the middle of a walk
        bus.start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            bus.start = 1'b0;
        end
        reset = 1'b0;
        #1;
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_index", 64'(bus.cpuIndex), 64'd0);
        check_table("midrst", 1'b1);
        idle(2);
        reset = 1'b1;
        idle(2);
        check("midrst_done_hold", 64'(bus.done), 64'd0);
        run_walk("fresh", 0);
        check_table("fresh", 1'b0);
        idle(2);

`ifdef JX2_CPUID_PROBE_RNG_EN
        // held request: first sample, then gap-limited second sample
        bus.rngReq = 1'b1;
        sb_q.push_back(resp_lo(5'h1F));
        ack_k = -1;
        for (int k = 1; k <= 10 && ack_k < 0; k++) begin
            tick();
            if (k == 1) check("rng_index31", 64'(bus.cpuIndex), 64'h1F);
            if (bus.rngAck) ack_k = k;
        end
        check("rng_first_latency", 64'(ack_k), 64'd2);
        check("rng_first_data", bus.rngData, sb_q.pop_front());
        tick();
        check("rng_ack_pulse", 64'(bus.rngAck), 64'd0);
        check("rng_data_held", bus.rngData, resp_lo(5'h1F));
        sb_q.push_back(resp_lo(5'h1F));
        ack_k = -1;
        for (int k = 2; k <= 80 && ack_k < 0; k++) begin
            tick();
            if (bus.rngAck) ack_k = k;
        end
        check("rng_gap_at_least", 64'(ack_k >= GAP), 64'd1);
        check("rng_second_data", bus.rngData, sb_q.pop_front());
        bus.rngReq = 1'b0;
        idle(40);

        // request dropped mid-sample still completes
        bus.rngReq = 1'b1;
        ack_k = -1;
        for (int k = 1; k <= 10 && ack_k < 0; k++) begin
            tick();
            bus.rngReq = 1'b0;
            if (bus.rngAck) ack_k = k;
        end
        check("rng_drop_latency", 64'(ack_k), 64'd2);
        idle(40);

        // start and rngReq together: walk first, sample afterwards
        bus.start  = 1'b1;
        bus.rngReq = 1'b1;
        done_k = -1;
        ack_k  = -1;
        for (int k = 1; k <= 30 && ack_k < 0; k++) begin
            tick();
            bus.start = 1'b0;
            if (bus.done && done_k < 0) done_k = k;
            if (bus.rngAck) ack_k = k;
        end
        bus.rngReq = 1'b0;
        check("conflict_done", 64'(done_k), 64'(WALK_LAT));
        check("conflict_ack", 64'(ack_k), 64'(WALK_LAT + 2));
        check_table("conflict", 1'b0);
        idle(2);
`else
        // entropy path absent: request is ignored
        bus.rngReq = 1'b1;
        cnt_ack = 0;
        cnt_idx = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (bus.rngAck) cnt_ack++;
            if (bus.cpuIndex == 5'h1F) cnt_idx++;
        end
        bus.rngReq = 1'b0;
        check("off_ack_count", 64'(cnt_ack), 64'd0);
        check("off_index31_count", 64'(cnt_idx), 64'd0);
        check("off_rng_data", bus.rngData, 64'd0);
        check("off_busy", 64'(bus.busy), 64'd0);
        run_walk("off_walk", 0);
        check_table("off_walk", 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
